// File: rtl/bus_master_port.sv
// Initiator end of the serial address/data bus: serialises a parallel request into
// address, ack wait, write/read data and (on writes) a second ack wait, with ack timeout.
module bus_master_port #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  M_START,
    input  logic                  M_RW,
    input  logic [ADDR_WIDTH-1:0] M_ADDR,
    input  logic [DATA_WIDTH-1:0] M_DIN,
    output logic                  M_READY,
    output logic                  M_DONE,
    output logic                  M_DVALID,
    output logic [DATA_WIDTH-1:0] M_DOUT,
    output logic                  M_ERR,
    output logic                  AD_SEL,
    output logic                  B_RW,
    output logic                  B_BUS_OUT,
    input  logic                  B_BUS_IN,
    input  logic                  B_ACK,
    input  logic                  B_SBSY
);

    localparam int MAX_AD  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int MAX_ALL = (MAX_AD > ACK_TIMEOUT) ? MAX_AD : ACK_TIMEOUT;
    localparam int CW      = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_A,
        WDATA,
        ACK_W,
        RDATA
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  rw_q, rw_d;
    logic                  hold_q, hold_d;
    logic                  ad_sel_q, ad_sel_d;
    logic                  b_rw_q, b_rw_d;
    logic                  bus_out_q, bus_out_d;
    logic                  done_q, done_d;
    logic                  dvalid_q, dvalid_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_shifted;
    logic [DATA_WIDTH-1:0] data_shifted;

    // hold_q blocks a restart in the first idle cycle after any transaction.
    assign M_READY = (state_q == IDLE) && !hold_q && !B_SBSY;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        rw_d         = rw_q;
        shift_d      = shift_q;
        dout_d       = dout_q;
        done_d       = 1'b0;
        dvalid_d     = 1'b0;
        err_d        = 1'b0;
        ad_sel_d     = 1'b0;
        b_rw_d       = 1'b0;
        bus_out_d    = 1'b0;
        addr_shifted = '0;
        data_shifted = '0;

        case (state_q)
            IDLE: begin
                if (M_START && M_READY) begin
                    state_d = ADDR;
                    addr_d  = M_ADDR;
                    data_d  = M_DIN;
                    rw_d    = M_RW;
                end
            end
            ADDR: begin
                if (cnt_q == ADDR_LAST) state_d = ACK_A;
            end
            ACK_A: begin
                if (B_ACK) begin
                    state_d = rw_q ? WDATA : RDATA;
                end else if (cnt_q == ACK_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            WDATA: begin
                if (cnt_q == DATA_LAST) state_d = ACK_W;
            end
            ACK_W: begin
                if (B_ACK) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (cnt_q == ACK_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            RDATA: begin
                // Shift in from the top so the first sampled bit ends up in bit 0.
                shift_d = {B_BUS_IN, shift_q[DATA_WIDTH-1:1]};
                if (cnt_q == DATA_LAST) begin
                    state_d  = IDLE;
                    dout_d   = shift_d;
                    done_d   = 1'b1;
                    dvalid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        cnt_d  = ((state_d != state_q) || (state_q == IDLE)) ? '0 : cnt_q + 1'b1;
        hold_d = (state_d == IDLE) && (state_q != IDLE);

        // Bus outputs are registered, so they are derived from the state/count being entered.
        addr_shifted = addr_d >> cnt_d;
        data_shifted = data_d >> cnt_d;
        if (state_d != IDLE) begin
            ad_sel_d = 1'b1;
            b_rw_d   = rw_d;
        end
        if (state_d == ADDR) begin
            bus_out_d = addr_shifted[0];
        end else if (state_d == WDATA) begin
            bus_out_d = data_shifted[0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            shift_q   <= '0;
            dout_q    <= '0;
            rw_q      <= 1'b0;
            hold_q    <= 1'b0;
            ad_sel_q  <= 1'b0;
            b_rw_q    <= 1'b0;
            bus_out_q <= 1'b0;
            done_q    <= 1'b0;
            dvalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            shift_q   <= shift_d;
            dout_q    <= dout_d;
            rw_q      <= rw_d;
            hold_q    <= hold_d;
            ad_sel_q  <= ad_sel_d;
            b_rw_q    <= b_rw_d;
            bus_out_q <= bus_out_d;
            done_q    <= done_d;
            dvalid_q  <= dvalid_d;
            err_q     <= err_d;
        end
    end

    assign M_DONE    = done_q;
    assign M_DVALID  = dvalid_q;
    assign M_DOUT    = dout_q;
    assign M_ERR     = err_q;
    assign AD_SEL    = ad_sel_q;
    assign B_RW      = b_rw_q;
    assign B_BUS_OUT = bus_out_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Self-checking bench for bus_master_port: directed and randomized transactions
// checked cycle by cycle against a phase-timing model derived from the bus protocol.
module tb_bus_master_port;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 15;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          M_START = 1'b0;
    logic          M_RW = 1'b0;
    logic [AW-1:0] M_ADDR = '0;
    logic [DW-1:0] M_DIN = '0;
    logic          B_BUS_IN = 1'b0;
    logic          B_ACK = 1'b0;
    logic          B_SBSY = 1'b0;
    logic          M_READY, M_DONE, M_DVALID, M_ERR;
    logic [DW-1:0] M_DOUT;
    logic          AD_SEL, B_RW, B_BUS_OUT;

    int            n_checks = 0;
    int            n_pass = 0;
    logic [DW-1:0] exp_dout = '0;

    always #5 CLK = ~CLK;

    bus_master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACK_TIMEOUT(TO)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .M_START  (M_START),
        .M_RW     (M_RW),
        .M_ADDR   (M_ADDR),
        .M_DIN    (M_DIN),
        .M_READY  (M_READY),
        .M_DONE   (M_DONE),
        .M_DVALID (M_DVALID),
        .M_DOUT   (M_DOUT),
        .M_ERR    (M_ERR),
        .AD_SEL   (AD_SEL),
        .B_RW     (B_RW),
        .B_BUS_OUT(B_BUS_OUT),
        .B_BUS_IN (B_BUS_IN),
        .B_ACK    (B_ACK),
        .B_SBSY   (B_SBSY)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic bit_at(input logic [31:0] v, input int k);
        logic [31:0] s;
        s = v >> k;
        return s[0];
    endfunction

    // One transaction. ack_a/ack_w: wait cycle (1..TO) in which the slave acks, 0 = never.
    // rst_cycle: transaction cycle during which RST is raised, 0 = none.
    // Cycle c is the clock period that follows the c-th edge after the start edge (start edge = edge 0).
    task automatic run_txn(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] din,
                           input logic [DW-1:0] rdata, input int ack_a, input int ack_w,
                           input int rst_cycle, input string name);
        int       a_wait, w_wait, d_lo, d_hi, w_lo, w_hi, last;
        logic     exp_done, exp_dvalid, exp_err, exp_bus;
        logic [6:0] exp_vec, obs_vec;

        a_wait     = (ack_a == 0) ? TO : ack_a;
        w_wait     = (ack_w == 0) ? TO : ack_w;
        d_lo       = AW + 1 + ack_a;
        d_hi       = AW + ack_a + DW;
        w_lo       = d_hi + 1;
        w_hi       = d_hi + w_wait;
        exp_done   = 1'b0;
        exp_dvalid = 1'b0;
        exp_err    = 1'b0;
        if (ack_a == 0) begin
            last    = AW + TO + 1;
            exp_err = 1'b1;
        end else if (!rw) begin
            last       = d_hi + 1;
            exp_done   = 1'b1;
            exp_dvalid = 1'b1;
        end else begin
            last     = w_hi + 1;
            exp_done = (ack_w != 0);
            exp_err  = (ack_w == 0);
        end

        M_START = 1'b1;
        M_RW    = rw;
        M_ADDR  = addr;
        M_DIN   = din;
        #1;
        check($sformatf("%s.ready_at_start", name), 32'(M_READY), 32'd1);
        step();

        for (int c = 1; c <= last; c++) begin
            if (c < last) begin
                if (c <= AW) exp_bus = bit_at(32'(addr), c - 1);
                else if (rw && ack_a != 0 && c >= d_lo && c <= d_hi) exp_bus = bit_at(32'(din), c - d_lo);
                else exp_bus = 1'b0;
                exp_vec = {1'b1, rw, exp_bus, 4'b0000};
            end else begin
                exp_vec = {3'b000, exp_done, exp_dvalid, exp_err, 1'b0};
            end
            obs_vec = {AD_SEL, B_RW, B_BUS_OUT, M_DONE, M_DVALID, M_ERR, M_READY};
            check($sformatf("%s.c%0d {sel,rw,bus,done,dval,err,rdy}", name, c), 32'(obs_vec), 32'(exp_vec));
            if (c == last) break;

            // Request side changes mid-transaction must be ignored; slave side is noise except where it matters.
            M_START  = 1'($urandom);
            M_RW     = 1'($urandom);
            M_ADDR   = AW'($urandom);
            M_DIN    = DW'($urandom);
            B_SBSY   = 1'($urandom);
            B_ACK    = 1'($urandom);
            B_BUS_IN = 1'($urandom);
            if (c > AW && c <= AW + a_wait) B_ACK = (c == AW + ack_a);
            if (rw && ack_a != 0 && c >= w_lo && c <= w_hi) B_ACK = (ack_w != 0) && (c == w_hi);
            if (!rw && ack_a != 0 && c >= d_lo && c <= d_hi) B_BUS_IN = bit_at(32'(rdata), c - d_lo);

            if (c == rst_cycle) begin
                RST     = 1'b1;
                M_START = 1'b0;
                B_SBSY  = 1'b0;
                B_ACK   = 1'b0;
                step();
                exp_dout = '0;
                check($sformatf("%s.rst {sel,rw,bus,done,dval,err}", name),
                      32'({AD_SEL, B_RW, B_BUS_OUT, M_DONE, M_DVALID, M_ERR}), 32'd0);
                check($sformatf("%s.rst_dout", name), 32'(M_DOUT), 32'(exp_dout));
                RST = 1'b0;
                step();
                check($sformatf("%s.after_rst {sel,done,err,rdy}", name),
                      32'({AD_SEL, M_DONE, M_ERR, M_READY}), 32'b0001);
                return;
            end
            step();
        end

        if (!rw && ack_a != 0) exp_dout = rdata;
        check($sformatf("%s.dout", name), 32'(M_DOUT), 32'(exp_dout));

        // A start in the return-to-idle cycle must be ignored.
        M_START = 1'($urandom);
        B_SBSY  = 1'b0;
        B_ACK   = 1'($urandom);
        step();
        check($sformatf("%s.post {sel,done,dval,err,rdy}", name),
              32'({AD_SEL, M_DONE, M_DVALID, M_ERR, M_READY}), 32'b00001);
        M_START = 1'b0;
        B_ACK   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] din, rdata;
        int            ack_a, ack_w;

        repeat (2) step();
        check("reset {sel,rw,bus,done,dval,err,rdy}",
              32'({AD_SEL, B_RW, B_BUS_OUT, M_DONE, M_DVALID, M_ERR, M_READY}), 32'b0000001);
        check("reset.dout", 32'(M_DOUT), 32'd0);
        B_SBSY = 1'b1;
        #1;
        check("reset.ready_busy", 32'(M_READY), 32'd0);
        B_SBSY = 1'b0;
        RST    = 1'b0;
        step();

        run_txn(1'b1, 16'h0014, 8'hA5, 8'h00, 1, 1, 0, "wr_basic");
        run_txn(1'b0, 16'h0008, 8'h00, 8'h3C, 3, 0, 0, "rd_basic");
        run_txn(1'b0, 16'h7E01, 8'h00, 8'hFF, 0, 0, 0, "rd_timeout_ackA");
        run_txn(1'b1, 16'h8001, 8'h96, 8'h00, 2, 0, 0, "wr_timeout_ackW");
        run_txn(1'b1, 16'hFFFF, 8'h81, 8'h00, TO, TO, 0, "wr_ack_last_cycle");

        B_SBSY  = 1'b1;
        M_START = 1'b1;
        #1;
        check("busy.ready", 32'(M_READY), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("busy.hold%0d {sel,rdy}", i), 32'({AD_SEL, M_READY}), 32'b00);
        end
        B_SBSY  = 1'b0;
        M_START = 1'b0;
        step();
        check("busy.released {sel,rdy}", 32'({AD_SEL, M_READY}), 32'b01);
        run_txn(1'b0, 16'h00F0, 8'h00, 8'h69, 1, 0, 0, "rd_after_busy");

        run_txn(1'b1, 16'h1234, 8'h5A, 8'h00, 2, 1, AW + 1 + 2 + 3, "wr_reset_bit3");
        run_txn(1'b0, 16'h4321, 8'h00, 8'hC3, 4, 0, 0, "rd_after_reset");

        for (int n = 0; n < 16; n++) begin
            rw    = 1'($urandom);
            addr  = AW'($urandom);
            din   = DW'($urandom);
            rdata = DW'($urandom);
            ack_a = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO));
            ack_w = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO));
            run_txn(rw, addr, din, rdata, ack_a, ack_w, 0, $sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
